voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of note_player voices scheduled.
REQ-002 Parameter STEAL_EN, default 1: when 1, allow stealing the oldest voice when all voices are busy.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 play  input  1  MCU play enable; when low, no new notes are accepted.
REQ-006 note_valid  input  1  a note request is present on note_in/duration_in.
REQ-007 note_ready  output  1  scheduler accepts the request this cycle.
REQ-008 note_in  input  6  note number; 0 is a rest.
REQ-009 duration_in  input  6  duration in beats.
REQ-010 voice_idle  input  NUM_VOICES  level input per voice; 1 = voice is finished (done_with_note).
REQ-011 load_voice  output  NUM_VOICES  one-hot, one-cycle load strobe to the selected voice.
REQ-012 note_to_load  output  6  note for the strobed voice; valid only while load_voice != 0.
REQ-013 duration_to_load  output  6  duration for the strobed voice; valid only while load_voice != 0.
REQ-014 voices_busy  output  NUM_VOICES  per-voice busy mask (not idle, or guarded).
REQ-015 stolen  output  1  one-cycle pulse, coincident with load_voice, when the load preempted a busy voice.

Function
REQ-016 FSM states: IDLE, ISSUE, GUARD.
REQ-017 IDLE: note_ready = play AND (any voice free OR STEAL_EN); a handshake occurs when note_valid AND note_ready are both high.
REQ-018 On a handshake with note_in = 0: the rest is consumed, no load is issued, and the FSM stays in IDLE.
REQ-019 On a handshake with note_in != 0: register the note, duration and the selected voice; go to ISSUE.
REQ-020 Voice selection: the lowest-index voice with voice_idle = 1 and not guarded; if none and STEAL_EN = 1, the voice with the oldest age rank; in that case stolen = 1.
REQ-021 ISSUE (1 cycle): drive load_voice one-hot with the registered note and duration; go to GUARD. Acceptance-to-strobe latency is exactly 1 cycle.
REQ-022 GUARD (1 cycle): note_ready = 0; the loaded voice is treated as busy regardless of voice_idle; return to IDLE.
REQ-023 Maximum throughput is one non-rest note per 3 cycles; rests are consumed at one per cycle.
REQ-024 Age ranks: each voice holds a rank in 0..NUM_VOICES-1, all distinct; 0 = newest.
REQ-025 Age update on ISSUE for voice v: ranks below the old rank[v] increment by 1; rank[v] becomes 0; other ranks are unchanged.
REQ-026 voices_busy[i] = NOT voice_idle[i], OR (i is the guarded voice while in ISSUE or GUARD).
REQ-027 If play falls while in ISSUE or GUARD, the sequence completes; no new handshake occurs until play is high again.
REQ-028 With STEAL_EN = 0 and all voices busy: note_ready = 0 and the request is held upstream.
REQ-029 A voice_idle change in the same cycle as selection uses the current-cycle value.

Reset
REQ-030 On reset: FSM = IDLE; load_voice = 0; stolen = 0; note_to_load = 0; duration_to_load = 0; note_ready = 0 until the first clock after reset deasserts.
REQ-031 On reset, age ranks initialise to rank[i] = NUM_VOICES-1-i, so voice 0 is oldest.
REQ-032 Reset mid-ISSUE suppresses the strobe; a registered request is discarded, not replayed.

Structure
REQ-033 The state encoding localparams and the REST note constant (0) belong in the shared music package.
REQ-034 Age tracking is a sub-module voice_age_tracker with inputs touch and touch_idx and output oldest_idx.
REQ-035 The scheduler drives the existing note_player load ports directly, replacing the shared new_note broadcast.

Verification
REQ-036 All voices idle, play = 1, request note 12 / duration 8 -> handshake in cycle t, load_voice = 3'b001 with note 12 / duration 8 in t+1, note_ready = 0 in t+1 and t+2.
REQ-037 Three back-to-back notes 10, 20, 30, all voices idle -> loads go to voices 0, 1, 2 in that order, 3 cycles apart.
REQ-038 All voices busy, STEAL_EN = 1, after loads to voices 0, 1, 2 -> next note 40 loads voice 0 with stolen = 1; a following note 41 loads voice 1.
REQ-039 All voices busy, STEAL_EN = 0 -> note_ready stays 0; raising voice_idle[2] -> handshake next cycle, then load_voice = 3'b100.
REQ-040 Rest (note 0) with note_valid held for 4 cycles -> 4 handshakes, load_voice stays 0.
REQ-041 Reset asserted during ISSUE -> load_voice = 0 immediately; after release, ranks are {2,1,0} for voices {0,1,2}, FSM is IDLE, note_ready = 1.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared music/scheduler definitions: field widths, rest note, FSM encoding.
package voice_scheduler_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_GUARD_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_GUARD = ST_GUARD_ENC
    } sched_state_t;

    // Index width that stays legal for a single-voice build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Note request handshake plus per-voice load/status bundle.
interface voice_scheduler_if
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3
);
    logic                  play;
    logic                  note_valid;
    logic                  note_ready;
    logic [NOTE_W-1:0]     note_in;
    logic [DUR_W-1:0]      duration_in;
    logic [NUM_VOICES-1:0] voice_idle;
    logic [NUM_VOICES-1:0] load_voice;
    logic [NOTE_W-1:0]     note_to_load;
    logic [DUR_W-1:0]      duration_to_load;
    logic [NUM_VOICES-1:0] voices_busy;
    logic                  stolen;

    modport master (
        output play, note_valid, note_in, duration_in, voice_idle,
        input  note_ready, load_voice, note_to_load, duration_to_load, voices_busy, stolen
    );

    modport slave (
        input  play, note_valid, note_in, duration_in, voice_idle,
        output note_ready, load_voice, note_to_load, duration_to_load, voices_busy, stolen
    );
endinterface

// File: rtl/voice_scheduler_age_tracker.sv
// Per-voice age ranks (0 = newest); reports the oldest voice as steal victim.
module voice_age_tracker
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] oldest_idx
);

    logic [NUM_VOICES-1:0][IDX_W-1:0] rank_q;

    // Touched voice becomes newest; only voices younger than it age by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= IDX_W'(NUM_VOICES - 1 - i);
            end
        end else if (touch) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    rank_q[i] <= '0;
                end else if (rank_q[i] < rank_q[touch_idx]) begin
                    rank_q[i] <= rank_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Accepts note requests and strobes them into free (or stolen) note_player voices.
//
//   state    | meaning
//   ST_IDLE  | ready for a request; rests are consumed here
//   ST_ISSUE | one-cycle load strobe to the selected voice
//   ST_GUARD | loaded voice held busy while its idle flag settles
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter bit STEAL_EN   = 1'b1
) (
    input logic               clk,
    input logic               reset,
    voice_scheduler_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_VOICES);

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      sel_q, free_idx, oldest_idx;
    logic [NOTE_W-1:0]     note_q;
    logic [DUR_W-1:0]      dur_q;
    logic                  stolen_q;
    logic                  rst_done_q;
    logic                  any_free;
    logic                  ready;
    logic                  accept;
    logic [NUM_VOICES-1:0] guard_mask;
    logic [NUM_VOICES-1:0] free_mask;
    logic [NUM_VOICES-1:0] load_voice;
    logic [NOTE_W-1:0]     note_to_load;
    logic [DUR_W-1:0]      duration_to_load;
    logic                  stolen;

    always_comb begin
        guard_mask = '0;
        if (state_q != ST_IDLE) begin
            guard_mask[sel_q] = 1'b1;
        end
    end

    assign free_mask = bus.voice_idle & ~guard_mask;

    // Descending scan so the lowest free index wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign ready  = rst_done_q && (state_q == ST_IDLE) && bus.play && (any_free || STEAL_EN);
    assign accept = ready && bus.note_valid && (bus.note_in != REST_NOTE);

    always_comb begin
        state_d          = state_q;
        load_voice       = '0;
        note_to_load     = '0;
        duration_to_load = '0;
        stolen           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                load_voice[sel_q] = 1'b1;
                note_to_load      = note_q;
                duration_to_load  = dur_q;
                stolen            = stolen_q;
                state_d           = ST_GUARD;
            end
            ST_GUARD: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rst_done_q <= 1'b0;
            sel_q      <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            stolen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (accept) begin
                note_q   <= bus.note_in;
                dur_q    <= bus.duration_in;
                sel_q    <= any_free ? free_idx : oldest_idx;
                stolen_q <= ~any_free;
            end
        end
    end

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_age (
        .clk        (clk),
        .reset      (reset),
        .touch      (state_q == ST_ISSUE),
        .touch_idx  (sel_q),
        .oldest_idx (oldest_idx)
    );

    assign bus.note_ready       = ready;
    assign bus.load_voice       = load_voice;
    assign bus.note_to_load     = note_to_load;
    assign bus.duration_to_load = duration_to_load;
    assign bus.stolen           = stolen;
    assign bus.voices_busy      = ~bus.voice_idle | guard_mask;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: scoreboarded load strobes, two steal configurations.
module tb_voice_scheduler;
    import voice_scheduler_pkg::*;

    typedef struct {
        logic [2:0] v;
        logic [5:0] n;
        logic [5:0] d;
        logic       s;
        int         c;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    voice_scheduler_if #(.NUM_VOICES(3)) bus_a ();
    voice_scheduler_if #(.NUM_VOICES(3)) bus_b ();

    voice_scheduler #(.NUM_VOICES(3), .STEAL_EN(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    voice_scheduler #(.NUM_VOICES(3), .STEAL_EN(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.load_voice !== 3'b000) begin
                if (sb_a.size() == 0) begin
                    chk("a_unexpected_load", 32'(bus_a.load_voice), 0);
                end else begin
                    e = sb_a.pop_front();
                    chk("a_load_voice", 32'(bus_a.load_voice), 32'(e.v));
                    chk("a_note", 32'(bus_a.note_to_load), 32'(e.n));
                    chk("a_dur", 32'(bus_a.duration_to_load), 32'(e.d));
                    chk("a_stolen", 32'(bus_a.stolen), 32'(e.s));
                    chk("a_latency", cyc, e.c);
                end
            end
            if (bus_b.load_voice !== 3'b000) begin
                if (sb_b.size() == 0) begin
                    chk("b_unexpected_load", 32'(bus_b.load_voice), 0);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_load_voice", 32'(bus_b.load_voice), 32'(e.v));
                    chk("b_note", 32'(bus_b.note_to_load), 32'(e.n));
                    chk("b_dur", 32'(bus_b.duration_to_load), 32'(e.d));
                    chk("b_stolen", 32'(bus_b.stolen), 32'(e.s));
                    chk("b_latency", cyc, e.c);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_a(input string tag, input logic [5:0] n, input logic [5:0] d,
                          input logic [2:0] exp_v, input logic exp_s, output int hs_cyc);
        int   waited;
        exp_t e;
        waited = 0;
        bus_a.note_valid  = 1'b1;
        bus_a.note_in     = n;
        bus_a.duration_in = d;
        #1;
        while (bus_a.note_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        hs_cyc = cyc;
        chk(tag, 32'(bus_a.note_ready), 1);
        if (bus_a.note_ready === 1'b1) begin
            e.v = exp_v; e.n = n; e.d = d; e.s = exp_s; e.c = cyc + 1;
            sb_a.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus_a.note_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_a.voice_idle = 3'b111;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   c0, c1, c2, hs, dummy;
        exp_t e;
        reset = 1'b1;
        bus_a.play = 1'b1; bus_a.note_valid = 1'b0; bus_a.note_in = '0;
        bus_a.duration_in = '0; bus_a.voice_idle = 3'b111;
        bus_b.play = 1'b1; bus_b.note_valid = 1'b0; bus_b.note_in = '0;
        bus_b.duration_in = '0; bus_b.voice_idle = 3'b000;
        fork
            monitor();
        join_none

        // Reset values, and note_ready held low until the first clock after release
        @(negedge clk);
        chk("rst_load_voice", 32'(bus_a.load_voice), 0);
        chk("rst_stolen", 32'(bus_a.stolen), 0);
        chk("rst_note_to_load", 32'(bus_a.note_to_load), 0);
        chk("rst_duration_to_load", 32'(bus_a.duration_to_load), 0);
        chk("rst_note_ready", 32'(bus_a.note_ready), 0);
        chk("rst_ranks", 32'(dut_a.u_age.rank_q), 32'h06);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_before_first_clk", 32'(bus_a.note_ready), 0);
        @(negedge clk);
        chk("ready_after_first_clk", 32'(bus_a.note_ready), 1);

        // Single note: strobe one cycle later, ready low for two cycles, guard forces busy
        send_a("hs_12", 6'd12, 6'd8, 3'b001, 1'b0, dummy);
        #1;
        chk("t1_ready", 32'(bus_a.note_ready), 0);
        chk("t1_busy_guard", 32'(bus_a.voices_busy), 32'h1);
        @(negedge clk);
        #1;
        chk("t2_ready", 32'(bus_a.note_ready), 0);
        chk("t2_busy_guard", 32'(bus_a.voices_busy), 32'h1);
        @(negedge clk);
        #1;
        chk("t3_ready", 32'(bus_a.note_ready), 1);
        chk("t3_busy", 32'(bus_a.voices_busy), 0);

        // Back-to-back notes fill voices 0,1,2 three cycles apart
        do_reset();
        send_a("hs_10", 6'd10, 6'd4, 3'b001, 1'b0, c0);
        bus_a.voice_idle[0] = 1'b0;
        send_a("hs_20", 6'd20, 6'd5, 3'b010, 1'b0, c1);
        bus_a.voice_idle[1] = 1'b0;
        send_a("hs_30", 6'd30, 6'd6, 3'b100, 1'b0, c2);
        bus_a.voice_idle[2] = 1'b0;
        chk("spacing_0_1", c1 - c0, 3);
        chk("spacing_1_2", c2 - c1, 3);
        #1;
        chk("all_busy", 32'(bus_a.voices_busy), 32'h7);

        // All busy with stealing: oldest voice 0, then voice 1
        send_a("hs_40", 6'd40, 6'd7, 3'b001, 1'b1, dummy);
        send_a("hs_41", 6'd41, 6'd9, 3'b010, 1'b1, dummy);

        // Rest held four cycles: four handshakes, no loads
        do_reset();
        bus_a.note_valid = 1'b1;
        bus_a.note_in = REST_NOTE;
        bus_a.duration_in = 6'd3;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rest_ready", 32'(bus_a.note_ready), 1);
            chk("rest_no_load", 32'(bus_a.load_voice), 0);
            if (bus_a.note_ready === 1'b1) hs++;
            @(negedge clk);
        end
        bus_a.note_valid = 1'b0;
        chk("rest_handshakes", hs, 4);

        // Age the ranks, then reset in the middle of ISSUE
        send_a("hs_7", 6'd7, 6'd2, 3'b001, 1'b0, dummy);
        @(negedge clk);
        @(negedge clk);
        bus_a.note_valid = 1'b1;
        bus_a.note_in = 6'd15;
        bus_a.duration_in = 6'd3;
        #1;
        chk("hs_15", 32'(bus_a.note_ready), 1);
        @(posedge clk);
        #1;
        chk("issue_before_reset", 32'(bus_a.load_voice), 32'h1);
        reset = 1'b1;
        #1;
        chk("issue_reset_load", 32'(bus_a.load_voice), 0);
        chk("issue_reset_note", 32'(bus_a.note_to_load), 0);
        bus_a.note_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_reset_ranks", 32'(dut_a.u_age.rank_q), 32'h06);
        chk("post_reset_state", 32'(dut_a.state_q), 32'(ST_IDLE));
        chk("post_reset_ready", 32'(bus_a.note_ready), 1);
        bus_a.play = 1'b0;
        #1;
        chk("play_low_ready", 32'(bus_a.note_ready), 0);
        bus_a.play = 1'b1;
        repeat (3) @(negedge clk);

        // No stealing: request held until voice 2 frees up
        bus_b.voice_idle = 3'b000;
        bus_b.note_valid = 1'b1;
        bus_b.note_in = 6'd50;
        bus_b.duration_in = 6'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nosteal_ready_low", 32'(bus_b.note_ready), 0);
            @(negedge clk);
        end
        bus_b.voice_idle = 3'b100;
        #1;
        chk("nosteal_ready_high", 32'(bus_b.note_ready), 1);
        if (bus_b.note_ready === 1'b1) begin
            e.v = 3'b100; e.n = 6'd50; e.d = 6'd5; e.s = 1'b0; e.c = cyc + 1;
            sb_b.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus_b.note_valid = 1'b0;
        repeat (3) @(negedge clk);

        #1;
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
